// File: rtl/txn_responder_pkg.sv
// txn_responder_pkg: shared widths, opcode/state enums and the response entry type
package txn_responder_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_INCR  = 2'd3
    } rsp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              err;
    } rsp_entry_t;
endpackage

// File: rtl/txn_responder_if.sv
// txn_responder_if: request and response valid/ready channels between requester and responder
interface txn_responder_if;
    import txn_responder_pkg::*;
    logic              req_valid;
    logic              req_ready;
    rsp_op_e           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ID_W-1:0]   req_id;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/txn_responder_rsp_fifo.sv
// txn_responder_rsp_fifo: synchronous FIFO of response entries with extra-bit wrap pointers
module txn_responder_rsp_fifo import txn_responder_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  rsp_entry_t din,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count,
    output rsp_entry_t head
);
    rsp_entry_t  mem_q [DEPTH];
    rsp_entry_t  mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = wr_q == rd_q;
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end
endmodule

// File: rtl/txn_responder.sv
// txn_responder: executes requests against a small register array and returns in-order buffered responses
module txn_responder import txn_responder_pkg::*; #(
    parameter int NUM_REGS  = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic busy,
    txn_responder_if.slave bus
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    resp_state_e       state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    rsp_entry_t        entry, head, last_q, last_d, shown;
    logic              accept, pop, in_range, full, empty;
    logic [CW-1:0]     count;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] cur, sum;

    assign bus.req_ready = state_q == ST_RUN && !full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign in_range      = bus.req_addr < ADDR_W'(NUM_REGS);
    assign idx           = bus.req_addr[IW-1:0];
    assign cur           = regs_q[idx];
    assign sum           = cur + bus.req_data;
    assign busy          = state_q != ST_IDLE || count != '0;
    // once the FIFO empties the outputs keep showing the last response that left
    assign shown         = empty ? last_q : head;
    assign bus.rsp_valid = !empty;
    assign bus.rsp_data  = shown.data;
    assign bus.rsp_id    = shown.id;
    assign bus.rsp_err   = shown.err;

    always_comb begin
        state_d = state_q == ST_IDLE ? (enable ? ST_RUN : ST_IDLE) :
                  enable ? ST_RUN : (state_q == ST_RUN || !empty) ? ST_DRAIN : ST_IDLE;
        entry.data = (!in_range || bus.req_op == OP_NOP) ? '0 : bus.req_op == OP_INCR ? sum : cur;
        entry.id   = bus.req_id;
        entry.err  = !in_range;
        regs_d = regs_q;
        if (accept && in_range && bus.req_op == OP_WRITE) regs_d[idx] = bus.req_data;
        if (accept && in_range && bus.req_op == OP_INCR) regs_d[idx] = sum;
        last_d = pop ? head : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            regs_q  <= '{default: '0};
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            last_q  <= last_d;
        end
    end

    txn_responder_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );
endmodule

// File: tb/tb_txn_responder.sv
// tb_txn_responder: directed table-driven bench plus backpressure, drain and reset sequences
module tb_txn_responder;
    import txn_responder_pkg::*;

    typedef struct {
        rsp_op_e     op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  id;
        logic [31:0] ed;
        logic [3:0]  eid;
        logic        ee;
    } vec_t;

    logic clk = 0, rst = 1, enable = 0, busy;
    int checks = 0, errors = 0;
    vec_t vt [14];
    vec_t bp [5];

    txn_responder_if bus();
    txn_responder dut (.clk(clk), .rst(rst), .enable(enable), .busy(busy), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.req_op   = v.op;
        bus.req_addr = v.addr;
        bus.req_data = v.data;
        bus.req_id   = v.id;
        bus.req_valid = 1;
    endtask

    task automatic chk_rsp(input string name, input vec_t v);
        chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({name, "_data"}, bus.rsp_data, v.ed);
        chk({name, "_id"}, 32'(bus.rsp_id), 32'(v.eid));
        chk({name, "_err"}, 32'(bus.rsp_err), 32'(v.ee));
    endtask

    initial begin
        int acc, n, pops;
        bit took, got5;
        vt[0]  = '{OP_WRITE, 4'd2,  32'hDEADBEEF, 4'd3,  32'h0,        4'd3,  1'b0};
        vt[1]  = '{OP_READ,  4'd2,  32'h0,        4'd4,  32'hDEADBEEF, 4'd4,  1'b0};
        vt[2]  = '{OP_WRITE, 4'd1,  32'hFFFFFFFF, 4'd5,  32'h0,        4'd5,  1'b0};
        vt[3]  = '{OP_INCR,  4'd1,  32'h2,        4'd6,  32'h1,        4'd6,  1'b0};
        vt[4]  = '{OP_READ,  4'd9,  32'h0,        4'd7,  32'h0,        4'd7,  1'b1};
        vt[5]  = '{OP_READ,  4'd8,  32'h0,        4'd8,  32'h0,        4'd8,  1'b1};
        vt[6]  = '{OP_READ,  4'd7,  32'h0,        4'd9,  32'h0,        4'd9,  1'b0};
        vt[7]  = '{OP_WRITE, 4'd7,  32'h12345678, 4'd10, 32'h0,        4'd10, 1'b0};
        vt[8]  = '{OP_INCR,  4'd7,  32'h1,        4'd11, 32'h12345679, 4'd11, 1'b0};
        vt[9]  = '{OP_NOP,   4'd2,  32'h55,       4'd12, 32'h0,        4'd12, 1'b0};
        vt[10] = '{OP_READ,  4'd2,  32'h0,        4'd13, 32'hDEADBEEF, 4'd13, 1'b0};
        vt[11] = '{OP_READ,  4'd1,  32'h0,        4'd14, 32'h1,        4'd14, 1'b0};
        vt[12] = '{OP_WRITE, 4'd15, 32'hFF,       4'd15, 32'h0,        4'd15, 1'b1};
        vt[13] = '{OP_READ,  4'd7,  32'h0,        4'd0,  32'h12345679, 4'd0,  1'b0};
        bp[0]  = '{OP_WRITE, 4'd3,  32'h10,       4'd1,  32'h0,        4'd1,  1'b0};
        bp[1]  = '{OP_INCR,  4'd3,  32'h5,        4'd2,  32'h15,       4'd2,  1'b0};
        bp[2]  = '{OP_READ,  4'd3,  32'h0,        4'd3,  32'h15,       4'd3,  1'b0};
        bp[3]  = '{OP_READ,  4'd2,  32'h0,        4'd4,  32'hDEADBEEF, 4'd4,  1'b0};
        bp[4]  = '{OP_READ,  4'd3,  32'h0,        4'd5,  32'h15,       4'd5,  1'b0};

        bus.req_valid = 0; bus.req_op = OP_NOP; bus.req_addr = 0; bus.req_data = 0; bus.req_id = 0;
        bus.rsp_ready = 1;
        enable = 1;
        step();
        rst = 0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        chk("run_req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i]);
            chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'd1);
            step();
            chk_rsp($sformatf("vec%0d", i), vt[i]);
        end
        bus.req_valid = 0;
        step();
        chk("after_vec_valid", 32'(bus.rsp_valid), 32'd0);

        bus.rsp_ready = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive(bp[acc]);
            took = bus.req_ready;
            step();
            if (took) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk_rsp("bp_hold", bp[0]);
        bus.rsp_ready = 1;
        n = 0; got5 = 0;
        for (int c = 0; c < 16 && n < 5; c++) begin
            if (bus.rsp_valid) begin
                chk_rsp($sformatf("bp_out%0d", n), bp[n]);
                n++;
            end
            took = bus.req_valid && bus.req_ready;
            step();
            if (took) begin
                bus.req_valid = 0;
                got5 = 1;
            end
        end
        chk("bp_out_count", 32'(n), 32'd5);
        chk("bp_fifth_accepted", 32'(got5), 32'd1);
        step();
        chk("empty_valid", 32'(bus.rsp_valid), 32'd0);
        chk("empty_hold_data", bus.rsp_data, 32'h15);
        chk("empty_hold_id", 32'(bus.rsp_id), 32'd5);

        bus.rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(vt[i]);
            step();
        end
        bus.req_valid = 0;
        enable = 0;
        bus.rsp_ready = 1;
        pops = bus.rsp_valid ? 1 : 0;
        step();
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_req_ready", 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < 10 && busy; c++) begin
            if (bus.rsp_valid) pops++;
            step();
        end
        chk("drain_pops", 32'(pops), 32'd3);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd0);

        enable = 1;
        step();
        bus.rsp_ready = 0;
        drive(vt[0]);
        step();
        step();
        bus.req_valid = 0;
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1;
        step();
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_data", bus.rsp_data, 32'd0);
        chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 0;
        bus.rsp_ready = 1;
        step();
        drive('{OP_READ, 4'd2, 32'h0, 4'd6, 32'h0, 4'd6, 1'b0});
        step();
        chk_rsp("post_rst_read", '{OP_READ, 4'd2, 32'h0, 4'd6, 32'h0, 4'd6, 1'b0});
        bus.req_valid = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
